// File: rtl/spi_dev_to_wb_pkg.sv
// Shared constants and parser state type for the SPI-to-Wishbone bridge.
package spi_dev_to_wb_pkg;

    localparam logic [7:0] CMD_WB = 8'hF0;

    localparam int MODE_WR     = 7;
    localparam int MODE_READDR = 6;
    localparam int MODE_INC    = 5;
    localparam int MODE_IGN    = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA
    } state_e;

endpackage

// File: rtl/spi_dev_to_wb_master.sv
// Wishbone cycle issue with a one-deep request queue and ack handshake.
// Read capture exists only when SPI_DEV_TO_WB_READ_EN is defined.
module spi_dev_to_wb_master
    import spi_dev_to_wb_pkg::*;
#(
    parameter int WB_N = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_v,
    input  logic              req_we,
    input  logic [3:0]        req_port,
    input  logic [23:0]       req_addr,
    input  logic [31:0]       req_data,
    output logic [31:0]       wb_wdata,
    input  logic [32*WB_N-1:0] wb_rdata,
    output logic [23:0]       wb_addr,
    output logic              wb_we,
    output logic [WB_N-1:0]   wb_cyc,
    input  logic [WB_N-1:0]   wb_ack,
    output logic [31:0]       rd_data,
    output logic              rd_valid
);

    logic [WB_N-1:0] cyc_q, cyc_d, req_sel;
    logic            we_q, we_d;
    logic [23:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            qv_q, qv_d, qwe_q, qwe_d;
    logic [WB_N-1:0] qsel_q, qsel_d;
    logic [23:0]     qaddr_q, qaddr_d;
    logic [31:0]     qdata_q, qdata_d;
    logic            ack_hit;

    always_comb begin
        req_sel = '0;
        for (int i = 0; i < WB_N; i++) begin
            req_sel[i] = (req_port == 4'(i));
        end
    end

    assign ack_hit = |(cyc_q & wb_ack);

    always_comb begin
        cyc_d   = cyc_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        qv_d    = qv_q;
        qwe_d   = qwe_q;
        qsel_d  = qsel_q;
        qaddr_d = qaddr_q;
        qdata_d = qdata_q;
        if (ack_hit) begin
            cyc_d = '0;
        end
        if (cyc_q == '0) begin
            if (qv_q) begin
                cyc_d   = qsel_q;
                we_d    = qwe_q;
                addr_d  = qaddr_q;
                wdata_d = qdata_q;
                qv_d    = req_v;
            end else if (req_v) begin
                cyc_d   = req_sel;
                we_d    = req_we;
                addr_d  = req_addr;
                wdata_d = req_data;
            end
        end else if (req_v) begin
            qv_d = 1'b1;
        end
        // Queue slot always captures a new request not issued directly.
        if (req_v && (cyc_q != '0 || qv_q)) begin
            qwe_d   = req_we;
            qsel_d  = req_sel;
            qaddr_d = req_addr;
            qdata_d = req_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            qv_q    <= 1'b0;
            qwe_q   <= 1'b0;
            qsel_q  <= '0;
            qaddr_q <= '0;
            qdata_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            qv_q    <= qv_d;
            qwe_q   <= qwe_d;
            qsel_q  <= qsel_d;
            qaddr_q <= qaddr_d;
            qdata_q <= qdata_d;
        end
    end

    assign wb_cyc   = cyc_q;
    assign wb_we    = we_q;
    assign wb_addr  = addr_q;
    assign wb_wdata = wdata_q;

`ifdef SPI_DEV_TO_WB_READ_EN
    logic [31:0] rword;
    logic [31:0] rd_data_q;
    logic        rd_valid_q;

    always_comb begin
        rword = '0;
        for (int i = 0; i < WB_N; i++) begin
            if (cyc_q[i]) rword = rword | wb_rdata[32*i +: 32];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= ack_hit && !we_q;
            if (ack_hit && !we_q) rd_data_q <= rword;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^wb_rdata;
    assign rd_data      = '0;
    assign rd_valid     = 1'b0;
`endif

endmodule

// File: rtl/spi_dev_to_wb.sv
// SPI byte stream to Wishbone master bridge: command/header/data parser.
// Define SPI_DEV_TO_WB_READ_EN to enable read-mode slots and rd_data.
module spi_dev_to_wb
    import spi_dev_to_wb_pkg::*;
#(
    parameter int WB_N = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         pw_wdata,
    input  logic               pw_wcmd,
    input  logic               pw_wstb,
    input  logic               pw_end,
    output logic [31:0]        wb_wdata,
    input  logic [32*WB_N-1:0] wb_rdata,
    output logic [23:0]        wb_addr,
    output logic               wb_we,
    output logic [WB_N-1:0]    wb_cyc,
    input  logic [WB_N-1:0]    wb_ack,
    output logic [31:0]        rd_data,
    output logic               rd_valid
);

    state_e      st_q, st_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  mode_q, mode_d;
    logic [23:0] addr_q, addr_d;
    logic [31:0] word_q, word_d;
    logic        hdr_done, slot_done;
    logic        req_v, req_we, rd_ok;
    logic [23:0] req_addr;
    logic        unused_mode;

`ifdef SPI_DEV_TO_WB_READ_EN
    assign rd_ok = 1'b1;
`else
    assign rd_ok = 1'b0;
`endif

    assign unused_mode = mode_q[MODE_IGN];
    assign req_we      = mode_q[MODE_WR];

    always_comb begin
        st_d      = st_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        addr_d    = addr_q;
        word_d    = word_q;
        hdr_done  = 1'b0;
        slot_done = 1'b0;
        req_v     = 1'b0;
        if (pw_wstb) begin
            if (pw_wcmd) begin
                st_d  = (pw_wdata == CMD_WB) ? ST_HDR : ST_IDLE;
                cnt_d = '0;
            end else begin
                unique case (st_q)
                    ST_HDR: begin
                        cnt_d = cnt_q + 2'd1;
                        unique case (cnt_q)
                            2'd0: mode_d = pw_wdata;
                            2'd1: addr_d[23:16] = pw_wdata;
                            2'd2: addr_d[15:8] = pw_wdata;
                            default: begin
                                addr_d[7:0] = pw_wdata;
                                st_d        = ST_DATA;
                                hdr_done    = 1'b1;
                            end
                        endcase
                    end
                    ST_DATA: begin
                        cnt_d  = cnt_q + 2'd1;
                        word_d = {word_q[23:0], pw_wdata};
                        if (cnt_q == 2'd3) begin
                            slot_done = 1'b1;
                            if (mode_q[MODE_READDR]) st_d = ST_HDR;
                        end
                    end
                    default: ;
                endcase
            end
        end
        // Reads prefetch at every slot start; writes fire at slot end.
        if (slot_done && req_we) req_v = 1'b1;
        if (!req_we && rd_ok &&
            (hdr_done || (slot_done && !mode_q[MODE_READDR])))
            req_v = 1'b1;
        if (32'(mode_q[3:0]) >= WB_N) req_v = 1'b0;
        req_addr = addr_d;
        if (req_v && mode_q[MODE_INC]) addr_d = addr_d + 24'd1;
        if (pw_end) begin
            st_d  = ST_IDLE;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            mode_q <= '0;
            addr_q <= '0;
            word_q <= '0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            addr_q <= addr_d;
            word_q <= word_d;
        end
    end

    spi_dev_to_wb_master #(.WB_N(WB_N)) u_master (
        .clk      (clk),
        .rst      (rst),
        .req_v    (req_v),
        .req_we   (req_we),
        .req_port (mode_q[3:0]),
        .req_addr (req_addr),
        .req_data (word_d),
        .wb_wdata (wb_wdata),
        .wb_rdata (wb_rdata),
        .wb_addr  (wb_addr),
        .wb_we    (wb_we),
        .wb_cyc   (wb_cyc),
        .wb_ack   (wb_ack),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

endmodule

// File: tb/tb_spi_dev_to_wb.sv
// Self-checking bench for spi_dev_to_wb with WB_N=3 and a latency-varying responder.
module tb_spi_dev_to_wb;

    localparam int N = 3;

`ifdef SPI_DEV_TO_WB_READ_EN
    localparam bit RD_EN = 1'b1;
`else
    localparam bit RD_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      pw_wdata;
    logic            pw_wcmd, pw_wstb, pw_end;
    logic [31:0]     wb_wdata;
    logic [32*N-1:0] wb_rdata;
    logic [23:0]     wb_addr;
    logic            wb_we;
    logic [N-1:0]    wb_cyc, wb_ack;
    logic [31:0]     rd_data;
    logic            rd_valid;

    always #5 clk = ~clk;

    spi_dev_to_wb #(.WB_N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .pw_wdata (pw_wdata),
        .pw_wcmd  (pw_wcmd),
        .pw_wstb  (pw_wstb),
        .pw_end   (pw_end),
        .wb_wdata (wb_wdata),
        .wb_rdata (wb_rdata),
        .wb_addr  (wb_addr),
        .wb_we    (wb_we),
        .wb_cyc   (wb_cyc),
        .wb_ack   (wb_ack),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    logic [31:0] exp_rd[$];
    logic [31:0] obs_rd[$];
    int lat_max = 1;
    int lat = 1;
    int wcnt = 0;
    int gap = 1;
    bit model_on = 1'b0;

    function automatic logic [31:0] rdf(input int p, input logic [23:0] a);
        if (p == 0 && a == 24'h111111) return 32'h600DBABE;
        return {4'h6, 4'(p), a};
    endfunction

    function automatic logic [63:0] key(input int p, input logic we,
                                        input logic [23:0] a, input logic [31:0] d);
        return {3'b000, 4'(p), we, a, (we ? d : 32'h0)};
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) wb_rdata[32*i +: 32] = rdf(i, wb_addr);
    end

    // Responder: ack after a random 1..lat_max cycle wait.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_ack <= '0;
            wcnt   <= 0;
            lat    <= 1;
        end else begin
            wb_ack <= '0;
            if (wb_cyc != '0 && wb_ack == '0) begin
                if (wcnt >= lat - 1) begin
                    wb_ack <= wb_cyc;
                    wcnt   <= 0;
                    lat    <= int'($urandom_range(1, lat_max));
                end else begin
                    wcnt <= wcnt + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    logic            hold_v = 1'b0;
    logic [59:0]     h_sig;

    always @(negedge clk) begin
        if (rst) begin
            if (hold_v)
                chk("hold", 64'(h_sig),
                    64'({wb_cyc, wb_we, wb_addr, (wb_we ? wb_wdata : 32'h0)}));
            if (wb_cyc != '0)
                chk("onehot", 64'($onehot(wb_cyc)), 64'd1);
            for (int i = 0; i < N; i++)
                if (wb_cyc[i] && wb_ack[i])
                    obs_q.push_back(key(i, wb_we, wb_addr, wb_wdata));
            hold_v = (wb_cyc != '0) && ((wb_cyc & wb_ack) == '0);
            h_sig  = {wb_cyc, wb_we, wb_addr, (wb_we ? wb_wdata : 32'h0)};
            if (rd_valid) obs_rd.push_back(rd_data);
        end
    end

    // Reference model: bytes of the current frame kept as a list.
    bit          m_armed = 1'b0;
    logic [7:0]  m_bytes[$];
    logic [7:0]  m_mode = '0;
    logic [23:0] m_addr = '0;

    task automatic m_issue(input logic we, input logic [31:0] d);
        int p;
        p = int'(m_mode[3:0]);
        if (p < N && (we || RD_EN)) begin
            exp_q.push_back(key(p, we, m_addr, d));
            if (!we) exp_rd.push_back(rdf(p, m_addr));
            if (m_mode[5]) m_addr = m_addr + 24'd1;
        end
    endtask

    task automatic m_byte(input logic [7:0] b, input logic cmd, input logic e);
        if (cmd) begin
            m_armed = (b == 8'hF0);
            m_bytes.delete();
        end else if (m_armed) begin
            m_bytes.push_back(b);
            if (m_bytes.size() == 4) begin
                m_mode = m_bytes[0];
                m_addr = {m_bytes[1], m_bytes[2], m_bytes[3]};
                if (!m_mode[7]) m_issue(1'b0, 32'h0);
            end else if (m_bytes.size() == 8) begin
                if (m_mode[7])
                    m_issue(1'b1, {m_bytes[4], m_bytes[5], m_bytes[6], m_bytes[7]});
                if (m_mode[6]) begin
                    m_bytes.delete();
                end else begin
                    repeat (4) void'(m_bytes.pop_back());
                    if (!m_mode[7]) m_issue(1'b0, 32'h0);
                end
            end
        end
        if (e) begin
            m_armed = 1'b0;
            m_bytes.delete();
        end
    endtask

    task automatic send(input logic [7:0] b, input logic cmd, input logic e);
        pw_wdata = b;
        pw_wcmd  = cmd;
        pw_wstb  = 1'b1;
        pw_end   = e;
        if (model_on) m_byte(b, cmd, e);
        @(posedge clk); #1;
        pw_wstb = 1'b0;
        pw_wcmd = 1'b0;
        pw_end  = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic end_pulse();
        pw_end = 1'b1;
        if (model_on) begin
            m_armed = 1'b0;
            m_bytes.delete();
        end
        @(posedge clk); #1;
        pw_end = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic hdr(input logic [7:0] m, input logic [23:0] a);
        send(m, 1'b0, 1'b0);
        send(a[23:16], 1'b0, 1'b0);
        send(a[15:8], 1'b0, 1'b0);
        send(a[7:0], 1'b0, 1'b0);
    endtask

    task automatic word(input logic [31:0] w);
        send(w[31:24], 1'b0, 1'b0);
        send(w[23:16], 1'b0, 1'b0);
        send(w[15:8], 1'b0, 1'b0);
        send(w[7:0], 1'b0, 1'b0);
    endtask

    task automatic drain(input string tag);
        int n;
        repeat (24) @(posedge clk);
        #1;
        chk({tag, ".ncyc"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, ".cyc"}, obs_q[i], exp_q[i]);
        chk({tag, ".nrd"}, 64'(obs_rd.size()), 64'(exp_rd.size()));
        n = (obs_rd.size() < exp_rd.size()) ? obs_rd.size() : exp_rd.size();
        for (int i = 0; i < n; i++) chk({tag, ".rd"}, 64'(obs_rd[i]), 64'(exp_rd[i]));
        obs_q.delete();
        exp_q.delete();
        obs_rd.delete();
        exp_rd.delete();
    endtask

    // Random-transaction state
    int          cut, nb, ns;
    bit          stop;
    logic [7:0]  rmode;
    logic [23:0] raddr;
    logic [7:0]  rb;

    task automatic rsend(input logic [7:0] b);
        if (stop) return;
        nb++;
        if (nb == cut) begin
            stop = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                send(b, 1'b0, 1'b1);
            end else begin
                send(b, 1'b0, 1'b0);
                end_pulse();
            end
        end else begin
            send(b, 1'b0, 1'b0);
        end
    endtask

    task automatic rhdr();
        rmode = 8'($urandom);
        rmode[3:0] = 4'($urandom_range(0, 3));
        raddr = ($urandom_range(0, 1) == 1) ? 24'hFFFFFE : 24'($urandom);
        rsend(rmode);
        rsend(raddr[23:16]);
        rsend(raddr[15:8]);
        rsend(raddr[7:0]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b0;
        pw_wdata = '0;
        pw_wcmd  = 1'b0;
        pw_wstb  = 1'b0;
        pw_end   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.cyc", 64'(wb_cyc), 64'd0);
        chk("rst.we", 64'(wb_we), 64'd0);
        chk("rst.addr", 64'(wb_addr), 64'd0);
        chk("rst.wdata", 64'(wb_wdata), 64'd0);
        chk("rst.rd_data", 64'(rd_data), 64'd0);
        chk("rst.rd_valid", 64'(rd_valid), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // All command bytes: never arms a data phase
        send(8'hF0, 1'b1, 1'b0);
        send(8'hA1, 1'b1, 1'b0);
        send(8'h12, 1'b1, 1'b0);
        send(8'h34, 1'b1, 1'b0);
        send(8'h56, 1'b1, 1'b0);
        drain("allcmd");

        send(8'hF0, 1'b1, 1'b0);
        hdr(8'hA1, 24'h123456);
        word(32'hB00B1E50);
        word(32'hCAFEBABE);
        exp_q.push_back(key(1, 1'b1, 24'h123456, 32'hB00B1E50));
        exp_q.push_back(key(1, 1'b1, 24'h123457, 32'hCAFEBABE));
        drain("wr_inc");

        send(8'hF0, 1'b1, 1'b0);
        hdr(8'h82, 24'h123456);
        word(32'hB00B1E50);
        word(32'hCAFEBABE);
        exp_q.push_back(key(2, 1'b1, 24'h123456, 32'hB00B1E50));
        exp_q.push_back(key(2, 1'b1, 24'h123456, 32'hCAFEBABE));
        drain("wr_fixed");

        send(8'hF0, 1'b1, 1'b0);
        hdr(8'hC2, 24'h222222);
        word(32'hB00B1E50);
        hdr(8'hC0, 24'h111111);
        word(32'hCAFEBABE);
        exp_q.push_back(key(2, 1'b1, 24'h222222, 32'hB00B1E50));
        exp_q.push_back(key(0, 1'b1, 24'h111111, 32'hCAFEBABE));
        drain("wr_readdr");

        send(8'hF0, 1'b1, 1'b0);
        hdr(8'h40, 24'h111111);
        word(32'h00000000);
        end_pulse();
        if (RD_EN) begin
            exp_q.push_back(key(0, 1'b0, 24'h111111, 32'h0));
            exp_rd.push_back(32'h600DBABE);
        end
        drain("read");
        chk("read.rd_data", 64'(rd_data), RD_EN ? 64'h600DBABE : 64'd0);

        send(8'hF0, 1'b1, 1'b0);
        hdr(8'h85, 24'h000000);
        send(8'hAB, 1'b0, 1'b0);
        end_pulse();
        send(8'hF0, 1'b1, 1'b0);
        hdr(8'h81, 24'h000010);
        word(32'hDEADBEEF);
        exp_q.push_back(key(1, 1'b1, 24'h000010, 32'hDEADBEEF));
        drain("abort");

        // Address wrap, then pw_end coincident with the final byte
        send(8'hF0, 1'b1, 1'b0);
        hdr(8'hA0, 24'hFFFFFF);
        word(32'h11223344);
        send(8'h55, 1'b0, 1'b0);
        send(8'h66, 1'b0, 1'b0);
        send(8'h77, 1'b0, 1'b0);
        send(8'h88, 1'b0, 1'b1);
        word(32'h99999999);
        exp_q.push_back(key(0, 1'b1, 24'hFFFFFF, 32'h11223344));
        exp_q.push_back(key(0, 1'b1, 24'h000000, 32'h55667788));
        drain("wrap_end");

        // Back-to-back bytes with slow acks exercise the queue
        lat_max = 3;
        gap = 0;
        send(8'hF0, 1'b1, 1'b0);
        hdr(8'hA2, 24'h000100);
        word(32'h01010101);
        word(32'h02020202);
        word(32'h03030303);
        exp_q.push_back(key(2, 1'b1, 24'h000100, 32'h01010101));
        exp_q.push_back(key(2, 1'b1, 24'h000101, 32'h02020202));
        exp_q.push_back(key(2, 1'b1, 24'h000102, 32'h03030303));
        drain("queue");

        model_on = 1'b1;
        for (int t = 0; t < 40; t++) begin
            lat_max = int'($urandom_range(1, 3));
            gap = int'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) begin
                rb = 8'($urandom);
                if (rb == 8'hF0) rb = 8'h0F;
                send(rb, 1'b1, 1'b0);
                send(8'h5A, 1'b0, 1'b0);
            end
            send(8'hF0, 1'b1, 1'b0);
            ns = int'($urandom_range(1, 3));
            nb = 0;
            stop = 1'b0;
            cut = ($urandom_range(0, 3) == 0) ?
                  int'($urandom_range(1, 4 + ns * 8)) : 1000;
            rhdr();
            for (int k = 0; k < ns; k++) begin
                if (k > 0 && rmode[6]) rhdr();
                for (int j = 0; j < 4; j++) rsend(8'($urandom));
            end
            if (!stop && $urandom_range(0, 1) == 1) end_pulse();
            drain("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_dev_to_wb.md
SPI_DEV_TO_WB -- requirements
Module: spi_dev_to_wb

Interface
REQ-001 SHALL have parameter WB_N, default 1, number of Wishbone target ports (legal range 1..16).
REQ-002 SHALL have port clk  input  1  sole clock; all logic is rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port pw_wdata  input  8  byte from the SPI protocol wrapper.
REQ-005 SHALL have port pw_wcmd  input  1  marks pw_wdata as a command byte.
REQ-006 SHALL have port pw_wstb  input  1  one-cycle byte-valid strobe.
REQ-007 SHALL have port pw_end  input  1  one-cycle end-of-transaction pulse (chip-select released).
REQ-008 SHALL have port wb_wdata  output  32  write data.
REQ-009 SHALL have port wb_rdata  input  32*WB_N  read data; slice n belongs to port n.
REQ-010 SHALL have port wb_addr  output  24  word address.
REQ-011 SHALL have port wb_we  output  1  1=write, 0=read.
REQ-012 SHALL have port wb_cyc  output  WB_N  one-hot cycle request per port.
REQ-013 SHALL have port wb_ack  input  WB_N  per-port acknowledge.
REQ-014 SHALL have port rd_data  output  32  last read word; rd_valid  output  1  one-cycle pulse when rd_data updates.

Function
REQ-015 SHALL act only on cycles with pw_wstb=1; a byte with pw_wcmd=1 always restarts the parser: 0xF0 arms WB mode, any other value returns to IDLE.
REQ-016 SHALL parse, while armed, pw_wcmd=0 bytes as: HDR (mode byte, then addr[23:16], [15:8], [7:0]) followed by 4-byte DATA slots, big-endian.
REQ-017 Mode byte SHALL decode: bit7 write(1)/read(0); bit6 re-address; bit5 auto-increment; bit4 ignored; bits[3:0] target port.
REQ-018 SHALL use states IDLE, HDR(byte 0..3), DATA(byte 0..3); a completed DATA slot goes to HDR if re-address=1, else DATA.
REQ-019 Write: on the 4th DATA byte SHALL issue a cycle with wb_we=1, wb_wdata=slot word, wb_addr=current address, registered (wb_cyc high the cycle after the strobe).
REQ-020 Read: SHALL issue a wb_we=0 cycle at each DATA slot start (HDR completion, or DATA completion without re-address); DATA bytes are don't-care; the final prefetch is accepted behaviour.
REQ-021 SHALL hold wb_cyc[port], wb_we, wb_addr, wb_wdata stable until wb_ack[port]=1, then drop wb_cyc the following cycle.
REQ-022 On read ack SHALL load rd_data from wb_rdata slice [32*port+31:32*port] and pulse rd_valid once.
REQ-023 After each issued cycle, auto-increment=1 SHALL add 1 to the address, wrapping 0xFFFFFF to 0x000000; otherwise the address is unchanged.
REQ-024 Port index >= WB_N SHALL issue no cycle; parsing continues.
REQ-025 A request arising while a cycle is outstanding SHALL queue one-deep and issue the cycle after ack; byte reception never stalls.
REQ-026 pw_end SHALL return the parser to IDLE, discarding partial header/slot bytes; an outstanding or queued cycle SHALL complete normally.
REQ-027 pw_end and pw_wstb in the same cycle: the byte is processed first, then pw_end applies.

Reset
REQ-028 While rst=0: wb_cyc=0, wb_we=0, wb_addr=0, wb_wdata=0, rd_data=0, rd_valid=0, parser IDLE, queue empty.

Configuration
REQ-029 With SPI_DEV_TO_WB_READ_EN defined SHALL support read mode as above; without it, read-mode slots issue no cycle, and rd_data/rd_valid are tied 0.

Structure
REQ-030 Package spi_dev_to_wb_pkg SHALL hold the 0xF0 command code, mode-bit positions and the parser state type.
REQ-031 Single sub-module spi_dev_to_wb_master SHALL hold the one-deep queue and the WB cycle/ack handshake.

Verification (WB_N=3, responder acks one cycle after cyc)
REQ-032 F0, then A1 12 34 56 all with pw_wcmd=1 -> no wb_cyc activity.
REQ-033 F0(cmd), A1 123456 B00B1E50 CAFEBABE (data) -> port 1 writes 0xB00B1E50@0x123456, 0xCAFEBABE@0x123457.
REQ-034 F0(cmd), 82 123456 B00B1E50 CAFEBABE (data) -> port 2 writes both words @0x123456.
REQ-035 F0(cmd), C2 222222 B00B1E50, C0 111111 CAFEBABE -> port 2 write 0xB00B1E50@0x222222, port 0 write 0xCAFEBABE@0x111111.
REQ-036 F0(cmd), 40 111111 + 4 dummy; port 0 returns 0x600DBABE -> wb_we=0, wb_cyc=3'b001, rd_data=0x600DBABE with one rd_valid pulse.
REQ-037 F0(cmd), 85 000000 AB, pw_end -> no cycle; following F0, 81 000010 DEADBEEF -> port 1 write 0xDEADBEEF@0x000010.
